// File: rtl/flag_status_register.sv
// Processor status word register: per-flag NZCV updates, full-word writes,
// and a LIFO save/restore stack with sticky protocol error bits.
module flag_status_register #(
    parameter int unsigned                  DATA_WIDTH  = 32,
    parameter int unsigned                  STACK_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0]        RESET_VALUE = '0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  n,
    input  logic                                  z,
    input  logic                                  c,
    input  logic                                  v,
    input  logic                                  update_n,
    input  logic                                  update_z,
    input  logic                                  update_c,
    input  logic                                  update_v,
    input  logic                                  write_en,
    input  logic [DATA_WIDTH-1:0]                 write_data,
    input  logic                                  push,
    input  logic                                  pop,
    input  logic                                  err_clear,
    output logic [DATA_WIDTH-1:0]                 flags,
    output logic [$clog2(STACK_DEPTH+1)-1:0]      stack_count,
    output logic                                  stack_full,
    output logic                                  stack_empty,
    output logic                                  overflow_err,
    output logic                                  underflow_err,
    output logic                                  protocol_err
);

    localparam int unsigned CW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_flags;
    logic [DATA_WIDTH-1:0] r_stack [STACK_DEPTH];
    logic [CW-1:0]         r_count;
    logic                  r_ovf;
    logic                  r_unf;
    logic                  r_proto;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic                  w_ovf_set;
    logic                  w_unf_set;
    logic                  w_proto_set;
    logic [IW-1:0]         w_wr_idx;
    logic [IW-1:0]         w_rd_idx;
    logic [DATA_WIDTH-1:0] w_next_flags;

    // Stack occupancy decode and request qualification
    always_comb begin
        w_full      = (r_count == CW'(STACK_DEPTH));
        w_empty     = (r_count == CW'(0));
        w_push_ok   = push & ~pop & ~w_full;
        w_pop_ok    = pop & ~push & ~w_empty;
        w_ovf_set   = push & ~pop & w_full;
        w_unf_set   = pop & ~push & w_empty;
        w_proto_set = push & pop;
        w_wr_idx    = IW'(r_count);
        w_rd_idx    = IW'(r_count - CW'(1));
    end

    // Next status word: restore > full write > per-flag update > hold
    always_comb begin
        w_next_flags = r_flags;
        if (w_pop_ok) begin
            w_next_flags = r_stack[w_rd_idx];
        end else if (write_en) begin
            w_next_flags = write_data;
        end else begin
            if (update_n) w_next_flags[DATA_WIDTH-1] = n;
            if (update_z) w_next_flags[DATA_WIDTH-2] = z;
            if (update_c) w_next_flags[DATA_WIDTH-3] = c;
            if (update_v) w_next_flags[DATA_WIDTH-4] = v;
        end
    end

    // Status word, stack, count and sticky error state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= RESET_VALUE;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_proto <= 1'b0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_flags <= w_next_flags;
            if (w_push_ok) begin
                r_stack[w_wr_idx] <= r_flags;
                r_count           <= r_count + CW'(1);
            end else if (w_pop_ok) begin
                r_count <= r_count - CW'(1);
            end
            // Set wins over clear
            r_ovf   <= w_ovf_set   | (r_ovf   & ~err_clear);
            r_unf   <= w_unf_set   | (r_unf   & ~err_clear);
            r_proto <= w_proto_set | (r_proto & ~err_clear);
        end
    end

    assign flags         = r_flags;
    assign stack_count   = r_count;
    assign stack_full    = w_full;
    assign stack_empty   = w_empty;
    assign overflow_err  = r_ovf;
    assign underflow_err = r_unf;
    assign protocol_err  = r_proto;

endmodule

// File: doc/flag_status_register.md
Name: flag_status_register

Overview:
Registered successor of the combinational flag updater. Holds the processor status word and applies per-flag N/Z/C/V updates on the clock edge, plus full-word writes (MSR-style). Adds a parametrised save/restore stack so the status word can be pushed on exception entry and popped on return. Sits between the ALU flag outputs and the condition-check/decode logic.

Parameters:
DATA_WIDTH, 32, status word width; N/Z/C/V occupy bits [DATA_WIDTH-1:DATA_WIDTH-4]; minimum 4
STACK_DEPTH, 4, number of saved status words; minimum 1
RESET_VALUE, 0, status word value after reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
n  in  1  ALU negative flag
z  in  1  ALU zero flag
c  in  1  ALU carry flag
v  in  1  ALU overflow flag
update_n  in  1  load n into bit DATA_WIDTH-1
update_z  in  1  load z into bit DATA_WIDTH-2
update_c  in  1  load c into bit DATA_WIDTH-3
update_v  in  1  load v into bit DATA_WIDTH-4
write_en  in  1  full-word write strobe
write_data  in  DATA_WIDTH  full-word write value
push  in  1  save current status word to stack
pop  in  1  restore status word from stack top
err_clear  in  1  clear sticky error bits
flags  out  DATA_WIDTH  registered status word
stack_count  out  clog2(STACK_DEPTH+1)  valid stack entries
stack_full  out  1  stack_count == STACK_DEPTH
stack_empty  out  1  stack_count == 0
overflow_err  out  1  sticky: push attempted while full
underflow_err  out  1  sticky: pop attempted while empty
protocol_err  out  1  sticky: push and pop in same cycle

Behaviour:
- All state updates on rising clk; all outputs registered or decoded from registers only; 1-cycle latency from any input to flags.
- reset dominates every other input: flags=RESET_VALUE, stack_count=0, all stack entries=0, all error bits=0, stack_empty=1, stack_full=0.
- Next-flags priority per cycle (highest first): valid pop > write_en > per-flag updates > hold.
  - Valid pop: flags <= stack top; write_en and update_* ignored that cycle.
  - write_en: flags <= write_data entirely; update_* ignored.
  - Otherwise each flag bit independently takes its ALU input when its update_* is 1; all other bits hold. Any combination of update_* permitted.
- Valid push (push=1, pop=0, not full): stack top <= current flags value (pre-edge, i.e. before this cycle's update/write); stack_count+1. Same-cycle write_en/update_* still apply to flags.
- Valid pop (pop=1, push=0, not empty): flags <= top entry; stack_count-1; popped entry need not be cleared.
- Push while full: stack and count unchanged; overflow_err<=1; flags update normally.
- Pop while empty: count unchanged; underflow_err<=1; flags follow write_en/update_* as if no pop.
- push and pop both 1: both ignored (stack, count unchanged, no restore); protocol_err<=1; flags follow write_en/update_*. Error checks of full/empty not applied in this case.
- Stack is LIFO; entries indexed by count, no wrap-around.
- err_clear clears all three sticky bits; if an error event occurs in the same cycle, the error bit is set (set wins over clear).
- stack_full/stack_empty derived from registered stack_count.

Test Plan:
- Reset then idle: flags=0x00000000, stack_empty=1, stack_count=0, errors 0; update_z=1,z=1 -> next cycle flags=0x40000000.
- Simultaneous updates: flags=0x0000_00FF, update_n,update_c=1 with n=1,c=1,z=1,v=1 -> flags=0xA00000FF (Z,V unchanged).
- Write vs update: write_en=1, write_data=0x12345678, update_n=1,n=1 same cycle -> flags=0x12345678.
- Push/pop round trip (STACK_DEPTH=4): flags=0x80000000, push while update_z=1,z=1 -> flags=0xC0000000, count=1; pop -> flags=0x80000000, count=0, stack_empty=1.
- Overflow/underflow: 5 pushes -> count=4, stack_full=1, overflow_err=1 after 5th; 5 pops -> count=0, underflow_err=1, flags equal first pushed value; err_clear -> both errors 0.
- push+pop same cycle with count=2 -> count stays 2, flags unchanged, protocol_err=1; reset asserted mid-sequence with count=3 -> next cycle count=0, flags=RESET_VALUE, errors 0.
